// File: rtl/tlb_entry_pkg.sv
// Shared TLB entry definitions used by the PTW, the TLB array and the
// refill queue between them. Flag order is fixed (bit 13 down to bit 0).
package tlb_entry_pkg;

  localparam int FLG_W     = 14;
  localparam int TLB_PPN_W = 20;

  // Flag bit positions inside the packed flg field
  localparam int FLG_U    = 13;
  localparam int FLG_G    = 12;
  localparam int FLG_AE   = 11;
  localparam int FLG_SW   = 10;
  localparam int FLG_SX   = 9;
  localparam int FLG_SR   = 8;
  localparam int FLG_PW   = 7;
  localparam int FLG_PX   = 6;
  localparam int FLG_PR   = 5;
  localparam int FLG_PAL  = 4;
  localparam int FLG_PAA  = 3;
  localparam int FLG_EFF  = 2;
  localparam int FLG_C    = 1;
  localparam int FLG_FRAG = 0;

  typedef logic [FLG_W-1:0] tlb_flg_t;

  // Default-width entry as seen by the TLB array and PTW
  typedef struct packed {
    logic [TLB_PPN_W-1:0] ppn;
    tlb_flg_t             flg;
  } tlb_entry_t;

  // Width of a slot index for a queue of the given depth (at least one bit)
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tlb_entry_queue_ptr.sv
// Modulo-DEPTH slot pointer. Wraps DEPTH-1 -> 0 explicitly so DEPTH need
// not be a power of two; clr returns it to slot 0.
module tlb_entry_queue_ptr
  import tlb_entry_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Pointer register: clear has priority over increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tlb_entry_queue.sv
// Ready/valid FIFO carrying TLB entry bundles from PTW refill responses to
// TLB array writes. Optional FLOW (empty bypass) and PIPE (enq while full if
// the head leaves) modes; io_flush discards everything on sfence/satp change.
module tlb_entry_queue
  import tlb_entry_pkg::*;
#(
  parameter  int PPN_W = 20,
  parameter  int DEPTH = 2,
  parameter  int FLOW  = 0,
  parameter  int PIPE  = 0,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [PPN_W-1:0] io_enq_bits_ppn,
  input  logic [FLG_W-1:0] io_enq_bits_flg,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [PPN_W-1:0] io_deq_bits_ppn,
  output logic [FLG_W-1:0] io_deq_bits_flg,
  output logic [CNT_W-1:0] io_count
);

  localparam logic FLOW_EN = (FLOW != 0);
  localparam logic PIPE_EN = (PIPE != 0);

  // Same layout as tlb_entry_t, but with the queue's own ppn width
  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    tlb_flg_t         flg;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;

  logic ptr_eq;
  logic empty;
  logic full;
  logic do_enq;
  logic do_deq;
  logic bypass;
  logic wr_en;
  logic rd_en;

  assign ptr_eq = (enq_ptr == deq_ptr);
  assign empty  = ptr_eq & ~maybe_full;
  assign full   = ptr_eq & maybe_full;

  // Flush masks both handshakes so nothing fires in the flush cycle
  assign io_enq_ready = ~io_flush & (~full | (PIPE_EN & io_deq_ready));
  assign io_deq_valid = ~io_flush & (~empty | (FLOW_EN & io_enq_valid));

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;

  // An entry passing straight through an empty FLOW queue never touches
  // storage; in that case do_deq implies do_enq, so both sides hold
  assign bypass = FLOW_EN & empty & do_deq;
  assign wr_en  = do_enq & ~bypass;
  assign rd_en  = do_deq & ~bypass;

  tlb_entry_queue_ptr #(.DEPTH(DEPTH)) u_enq_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (wr_en),
    .clr   (io_flush),
    .ptr   (enq_ptr)
  );

  tlb_entry_queue_ptr #(.DEPTH(DEPTH)) u_deq_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (rd_en),
    .clr   (io_flush),
    .ptr   (deq_ptr)
  );

  // maybe_full distinguishes full from empty when the pointers coincide;
  // it only changes when exactly one side moves
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      maybe_full <= 1'b0;
    end else if (io_flush) begin
      maybe_full <= 1'b0;
    end else if (wr_en != rd_en) begin
      maybe_full <= wr_en;
    end
  end

  // Entry storage is data only and deliberately left unreset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[enq_ptr] <= '{ppn: io_enq_bits_ppn, flg: io_enq_bits_flg};
    end
  end

  // Head selection: an empty FLOW queue shows the incoming entry directly
  always_comb begin
    io_deq_bits_ppn = mem[deq_ptr].ppn;
    io_deq_bits_flg = mem[deq_ptr].flg;
    if (FLOW_EN && empty) begin
      io_deq_bits_ppn = io_enq_bits_ppn;
      io_deq_bits_flg = io_enq_bits_flg;
    end
  end

  // Occupancy without relying on power-of-two pointer wrap
  always_comb begin
    io_count = '0;
    if (ptr_eq) begin
      io_count = maybe_full ? CNT_W'(DEPTH) : '0;
    end else if (enq_ptr > deq_ptr) begin
      io_count = CNT_W'(int'(enq_ptr) - int'(deq_ptr));
    end else begin
      io_count = CNT_W'(DEPTH + int'(enq_ptr) - int'(deq_ptr));
    end
  end

endmodule
